// File: rtl/lfsr_frame_sequencer.sv
// lfsr_frame_sequencer
//
// Sequences an external NUM_BITS-wide XNOR LFSR to produce framed pseudo-random
// sample streams. A start command latches the seed, frame length, frame count
// and repeat mode. The block then loads the seed into the LFSR and steps it once
// per accepted sample over a valid/ready handshake.
//
// In repeat mode the LFSR is reseeded at every frame start, so every frame is
// identical. Otherwise the sequence runs on across frame boundaries.
//
// Ports:
//   i_Clk, i_Rst_n       clock, asynchronous active-low reset
//   i_Start, i_Abort     run control (start honoured in idle, abort when busy)
//   i_Seed, i_Frame_Len,
//   i_Num_Frames,
//   i_Repeat             run configuration, latched on start
//   o_Busy               high whenever not idle
//   o_Sample_Valid,
//   i_Sample_Ready,
//   o_Sample_Data,
//   o_Sample_Last        sample stream handshake
//   o_Frame_Idx          index of the frame being emitted
//   o_Done               one-cycle pulse on normal completion
//   o_Seed_DV,
//   o_Seed_Data,
//   o_LFSR_Enable        control of the attached LFSR
//   i_LFSR_Data          current LFSR state

module lfsr_frame_sequencer #(
  parameter int unsigned NUM_BITS = 5,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned FRM_W    = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Start,
  input  logic                i_Abort,
  input  logic [NUM_BITS-1:0] i_Seed,
  input  logic [LEN_W-1:0]    i_Frame_Len,
  input  logic [FRM_W-1:0]    i_Num_Frames,
  input  logic                i_Repeat,
  output logic                o_Busy,
  output logic                o_Sample_Valid,
  input  logic                i_Sample_Ready,
  output logic [NUM_BITS-1:0] o_Sample_Data,
  output logic                o_Sample_Last,
  output logic [FRM_W-1:0]    o_Frame_Idx,
  output logic                o_Done,
  output logic                o_Seed_DV,
  output logic [NUM_BITS-1:0] o_Seed_Data,
  output logic                o_LFSR_Enable,
  input  logic [NUM_BITS-1:0] i_LFSR_Data
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSeed = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched run configuration
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [FRM_W-1:0]    frames_q, frames_d;
  logic                repeat_q, repeat_d;

  // Position within the run
  logic [LEN_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [FRM_W-1:0]    frame_idx_q, frame_idx_d;

  logic                in_run;
  logic                accept;
  logic                last_sample;
  logic                last_frame;
  logic [NUM_BITS-1:0] seed_load;

  assign in_run      = (state_q == StRun);
  assign accept      = in_run & i_Sample_Ready;
  // len_q and frames_q are never zero while in RUN, so the subtractions cannot wrap.
  assign last_sample = (sample_cnt_q == len_q - LEN_W'(1));
  assign last_frame  = (frame_idx_q == frames_q - FRM_W'(1));

  // All-ones is the XNOR lock-up state; load all-zeros instead.
  assign seed_load = (seed_q == {NUM_BITS{1'b1}}) ? '0 : seed_q;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    len_d        = len_q;
    frames_d     = frames_q;
    repeat_d     = repeat_q;
    sample_cnt_d = sample_cnt_q;
    frame_idx_d  = frame_idx_q;

    unique case (state_q)
      StIdle: begin
        if (i_Start) begin
          seed_d       = i_Seed;
          len_d        = i_Frame_Len;
          frames_d     = i_Num_Frames;
          repeat_d     = i_Repeat;
          sample_cnt_d = '0;
          frame_idx_d  = '0;
          if ((i_Frame_Len == '0) || (i_Num_Frames == '0)) begin
            state_d = StDone;
          end else begin
            state_d = StSeed;
          end
        end
      end

      StSeed: begin
        state_d = StRun;
      end

      StRun: begin
        if (accept) begin
          if (last_sample) begin
            if (last_frame) begin
              state_d = StDone;
            end else begin
              frame_idx_d  = frame_idx_q + FRM_W'(1);
              sample_cnt_d = '0;
              // Repeat mode reseeds, which costs one valid-low cycle per frame.
              state_d      = repeat_q ? StSeed : StRun;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + LEN_W'(1);
          end
        end
      end

      StDone: begin
        state_d      = StIdle;
        sample_cnt_d = '0;
        frame_idx_d  = '0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides every other transition; an acceptance in this cycle is dropped.
    if ((state_q != StIdle) && i_Abort) begin
      state_d      = StIdle;
      sample_cnt_d = '0;
      frame_idx_d  = '0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= StIdle;
      seed_q       <= '0;
      len_q        <= '0;
      frames_q     <= '0;
      repeat_q     <= 1'b0;
      sample_cnt_q <= '0;
      frame_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      len_q        <= len_d;
      frames_q     <= frames_d;
      repeat_q     <= repeat_d;
      sample_cnt_q <= sample_cnt_d;
      frame_idx_q  <= frame_idx_d;
    end
  end

  // Outputs
  always_comb begin
    o_Busy         = (state_q != StIdle);
    o_Sample_Valid = in_run;
    // The LFSR only steps on acceptance, so data holds stable under backpressure.
    o_Sample_Data  = in_run ? i_LFSR_Data : '0;
    o_Sample_Last  = in_run & last_sample;
    o_Frame_Idx    = frame_idx_q;
    // An abort in DONE suppresses the completion pulse.
    o_Done         = (state_q == StDone) & ~i_Abort;
    o_Seed_DV      = (state_q == StSeed);
    o_Seed_Data    = (state_q == StSeed) ? seed_load : '0;
    o_LFSR_Enable  = (state_q == StSeed) | accept;
  end

endmodule

// File: doc/lfsr_frame_sequencer.md
Name: lfsr_frame_sequencer

Overview:
Controller that sequences a NUM_BITS-wide XNOR LFSR to produce framed pseudo-random sample streams for the coherent-average datapath and testbenches. On a start command it loads a seed into the LFSR and steps it once per accepted sample. It emits i_Num_Frames frames of i_Frame_Len samples each over a valid/ready handshake. In repeat mode it reseeds at every frame start, so all frames are identical and suitable for coherent accumulation. Otherwise the sequence runs on across frame boundaries, giving uncorrelated noise.

Parameters:
NUM_BITS, 5, LFSR width; must match the attached LFSR (3..32).
LEN_W, 16, width of the frame-length field.
FRM_W, 16, width of the frame-count and frame-index fields.

Ports:
i_Clk  in  1  clock.
i_Rst_n  in  1  asynchronous active-low reset.
i_Start  in  1  start pulse; honoured only in IDLE.
i_Abort  in  1  abort run; honoured in any non-IDLE state.
i_Seed  in  NUM_BITS  seed value; latched on start.
i_Frame_Len  in  LEN_W  samples per frame; latched on start.
i_Num_Frames  in  FRM_W  frames per run; latched on start.
i_Repeat  in  1  1 = reseed at every frame start; latched on start.
o_Busy  out  1  high in any state other than IDLE.
o_Sample_Valid  out  1  sample available.
i_Sample_Ready  in  1  downstream accepts the sample.
o_Sample_Data  out  NUM_BITS  equals i_LFSR_Data while valid, 0 otherwise.
o_Sample_Last  out  1  high with valid on the last sample of each frame.
o_Frame_Idx  out  FRM_W  index of the current frame, starting at 0.
o_Done  out  1  one-cycle pulse when a run completes normally.
o_Seed_DV  out  1  to LFSR seed-load strobe.
o_Seed_Data  out  NUM_BITS  to LFSR seed value.
o_LFSR_Enable  out  1  to LFSR enable.
i_LFSR_Data  in  NUM_BITS  from LFSR current state.

Behaviour:
- Reset (asynchronous, i_Rst_n=0):
  - State goes to IDLE.
  - All outputs are 0, and all counters and latched config are 0.
- States are IDLE, SEED, RUN and DONE.
- IDLE:
  - On i_Start=1, latch the seed, length, frame count and repeat bit, then go to SEED.
  - If the latched length or frame count is 0, go to DONE directly instead; no samples are emitted.
- SEED (exactly one cycle):
  - Drive o_Seed_DV=1 and o_LFSR_Enable=1, with o_Seed_Data set to the latched seed.
  - If the latched seed is all ones (the XNOR lock-up state), substitute all zeros.
  - Next state is RUN. One cycle later, i_LFSR_Data equals the seed.
- RUN:
  - o_Sample_Valid=1.
  - o_LFSR_Enable = o_Sample_Valid & i_Sample_Ready, i.e. the LFSR steps exactly once per accepted sample.
  - The sample counter increments on each acceptance.
  - o_Sample_Last=1 when the sample counter = frame length-1.
- Acceptance of the last sample of a frame:
  - If it is the last frame, go to DONE.
  - Else, if repeat is set: increment o_Frame_Idx, clear the sample counter and go to SEED. This inserts one cycle with valid low between frames.
  - Else: increment o_Frame_Idx, clear the sample counter and stay in RUN. The next frame is back-to-back and continues the sequence.
- Data stability: while valid=1 and ready=0, o_Sample_Data and o_Sample_Last hold stable.
- DONE (one cycle): o_Done=1, then go to IDLE.
- i_Abort=1 in SEED, RUN or DONE:
  - Go to IDLE on the next edge.
  - No o_Done pulse is generated, and an accepted sample in that cycle does not count.
  - The LFSR may have stepped; this is harmless.
- Abort takes priority over all other transitions.
- i_Start is ignored while busy.
- Simultaneous i_Start and i_Abort in IDLE: start is honoured.
- Counters: the sample counter is LEN_W bits and o_Frame_Idx is FRM_W bits; neither wraps, since the maxima bound them.
- Latency: start edge to first valid sample is 2 cycles (SEED, then RUN).
- Inputs are sampled only on start; changes to them during a run have no effect.

Test Plan:
- NUM_BITS=5, seed=0x01, len=4, frames=3, repeat=1, ready always 1:
  - Each frame is 0x01, 0x03, 0x07, 0x0E, with Last on 0x0E.
  - Valid is low for one cycle between frames.
  - o_Frame_Idx steps 0, 1, 2.
  - o_Done pulses once, one cycle after the last acceptance.
- Same configuration with repeat=0:
  - Frame 0 is 0x01, 0x03, 0x07, 0x0E; frame 1 is 0x1C, 0x19, 0x12, then the sequence continues.
  - No valid gap appears between frames.
- Backpressure: toggle ready pseudo-randomly:
  - Data holds while ready=0.
  - Exactly len×frames acceptances occur.
  - o_LFSR_Enable pulse count = acceptances + seed loads.
- Seed=0x1F:
  - o_Seed_Data=0x00 during SEED.
  - The first sample is 0x00 and the second is 0x01.
- len=0 or frames=0:
  - o_Done is asserted 1 cycle after start.
  - No valid is ever asserted and o_Seed_DV stays low.
- Abort during frame 1, plus a separate run with i_Rst_n pulsed low mid-run:
  - All outputs go to 0.
  - No o_Done pulse.
  - A subsequent start produces the correct frame 0 from the seed.
